// File: rtl/mix_columns_seq_pkg.sv
// Shared AES definitions for the MixColumns sequencer: widths, byte/word/state
// types, FSM encoding and GF(2^8) multiply helpers.
// Optional feature macro: MIXCOL_INV_EN (adds gf_mul9/b/d/e for InvMixColumns).
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_WORD_W  = 32;

  typedef logic [7:0]             aes_byte_t;
  typedef logic [AES_WORD_W-1:0]  aes_word_t;
  typedef logic [AES_STATE_W-1:0] aes_state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } mc_state_e;

  function automatic aes_byte_t gf_xtime(input aes_byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_byte_t gf_mul3(input aes_byte_t a);
    return gf_xtime(a) ^ a;
  endfunction

`ifdef MIXCOL_INV_EN
  // x2/x4/x8 partial products come from chained xtime; no multiplier tables.
  function automatic aes_byte_t gf_mul9(input aes_byte_t a);
    aes_byte_t x2, x4, x8;
    x2 = gf_xtime(a);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return x8 ^ a;
  endfunction

  function automatic aes_byte_t gf_mulb(input aes_byte_t a);
    aes_byte_t x2, x4, x8;
    x2 = gf_xtime(a);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return x8 ^ x2 ^ a;
  endfunction

  function automatic aes_byte_t gf_muld(input aes_byte_t a);
    aes_byte_t x2, x4, x8;
    x2 = gf_xtime(a);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return x8 ^ x4 ^ a;
  endfunction

  function automatic aes_byte_t gf_mule(input aes_byte_t a);
    aes_byte_t x2, x4, x8;
    x2 = gf_xtime(a);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction
`endif

endpackage

// File: rtl/mix_columns_seq_if.sv
// Handshake bundle for the MixColumns sequencer: input state channel, output
// state channel and busy status. The slave modport is the sequencer side.
// Optional feature macro: MIXCOL_INV_EN (adds in_inverse to the input channel).
interface mix_columns_seq_if;
  import aes_pkg::*;

  logic       in_valid;
  logic       in_ready;
  aes_state_t in_state;
  logic       out_valid;
  logic       out_ready;
  aes_state_t out_state;
  logic       busy;
`ifdef MIXCOL_INV_EN
  logic       in_inverse;

  modport slave (
    input  in_valid, in_state, in_inverse, out_ready,
    output in_ready, out_valid, out_state, busy
  );

  modport master (
    output in_valid, in_state, in_inverse, out_ready,
    input  in_ready, out_valid, out_state, busy
  );
`else
  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state, busy
  );

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state, busy
  );
`endif

endinterface

// File: rtl/mix_columns_seq_mix_column_word.sv
// Combinational transform of one 32-bit AES column (row 0 in the MSB byte).
// Forward: b_r = 2*a_r ^ 3*a_r+1 ^ a_r+2 ^ a_r+3 (indices mod 4).
// Optional feature macro: MIXCOL_INV_EN (inverse input selects InvMixColumns).
module mix_column_word
  import aes_pkg::*;
(
  input  aes_word_t col_in,
`ifdef MIXCOL_INV_EN
  input  logic      inverse,
`endif
  output aes_word_t col_out
);

  aes_byte_t a [4];
  aes_byte_t b [4];

  // Split the column into rows, apply the rotated coefficient set, repack.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      a[r] = col_in[31-8*r -: 8];
    end
    for (int r = 0; r < 4; r++) begin
      b[r] = gf_xtime(a[r]) ^ gf_mul3(a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
`ifdef MIXCOL_INV_EN
      if (inverse) begin
        b[r] = gf_mule(a[r]) ^ gf_mulb(a[(r+1)%4]) ^ gf_muld(a[(r+2)%4]) ^ gf_mul9(a[(r+3)%4]);
      end
`endif
    end
    col_out = '0;
    for (int r = 0; r < 4; r++) begin
      col_out[31-8*r -: 8] = b[r];
    end
  end

endmodule

// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns sequencer. Accepts a 128-bit state, transforms
// COLS_PER_CYCLE columns per cycle in place, then holds the result until the
// output handshake completes. COLS_PER_CYCLE must be 1, 2 or 4.
// Optional feature macro: MIXCOL_INV_EN (in_inverse selects InvMixColumns).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | in_ready=1, waiting for an input state
//   RUN     | transforming columns col_cnt.. in the work register
//   HOLD    | out_valid=1, out_state frozen until out_ready
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  mix_columns_seq_if.slave  bus
);

  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] COL_LAST = 2'(4 - COLS_PER_CYCLE);

  mc_state_e  state_q;
  mc_state_e  state_d;
  logic [1:0] col_cnt;
  aes_state_t work_q;
  aes_state_t work_next;
  aes_state_t out_state_q;
  logic       last_step;

  aes_word_t  cols_q   [4];
  aes_word_t  cols_d   [4];
  logic [1:0] col_idx  [COLS_PER_CYCLE];
  aes_word_t  col_res  [COLS_PER_CYCLE];

`ifdef MIXCOL_INV_EN
  logic       inv_q;
`endif

  assign last_step = (col_cnt == COL_LAST);

  // Column c of the work register sits at [127-32c -: 32].
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      cols_q[c] = work_q[AES_STATE_W-1-AES_WORD_W*c -: AES_WORD_W];
    end
  end

  for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_col
    assign col_idx[i] = col_cnt + 2'(i);

    mix_column_word u_mcw (
      .col_in  (cols_q[col_idx[i]]),
`ifdef MIXCOL_INV_EN
      .inverse (inv_q),
`endif
      .col_out (col_res[i])
    );
  end

  // Replace the columns handled this cycle, keep the rest, repack.
  always_comb begin
    cols_d = cols_q;
    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
      cols_d[col_idx[i]] = col_res[i];
    end
    work_next = '0;
    for (int c = 0; c < 4; c++) begin
      work_next[AES_STATE_W-1-AES_WORD_W*c -: AES_WORD_W] = cols_d[c];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic; in HOLD only the output handshake is considered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid)  state_d = ST_RUN;
      ST_RUN:  if (last_step)     state_d = ST_HOLD;
      ST_HOLD: if (bus.out_ready) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE);
    bus.out_valid = (state_q == ST_HOLD);
    bus.busy      = (state_q != ST_IDLE);
    bus.out_state = out_state_q;
  end

  // Datapath: capture on acceptance, transform in RUN, publish on last column.
  always_ff @(posedge clk) begin
    if (rst) begin
      work_q      <= '0;
      col_cnt     <= 2'd0;
      out_state_q <= '0;
`ifdef MIXCOL_INV_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            work_q  <= bus.in_state;
            col_cnt <= 2'd0;
`ifdef MIXCOL_INV_EN
            inv_q   <= bus.in_inverse;
`endif
          end
        end
        ST_RUN: begin
          work_q  <= work_next;
          col_cnt <= col_cnt + COL_STEP;
          if (last_step) out_state_q <= work_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq with COLS_PER_CYCLE = 1, 2 and 4.
// Expected states are FIPS-197 / hand-computed MixColumns results.
module tb_mix_columns_seq;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  localparam aes_state_t V1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam aes_state_t R1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam aes_state_t V2 = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam aes_state_t R2 = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam aes_state_t V3 = 128'h6347a2f0_01020304_2d26314c_d4d4d4d5;
  localparam aes_state_t R3 = 128'h5de070bb_0304090a_4d7ebdf8_d5d5d7d6;
  localparam aes_state_t JUNK = 128'h0123456789abcdef_fedcba9876543210;

  always #5 clk = ~clk;

  mix_columns_seq_if if1 ();
  mix_columns_seq_if if2 ();
  mix_columns_seq_if if4 ();

  mix_columns_seq #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    if1.in_valid = 1'b0; if1.in_state = '0; if1.out_ready = 1'b0;
    if2.in_valid = 1'b0; if2.in_state = '0; if2.out_ready = 1'b0;
    if4.in_valid = 1'b0; if4.in_state = '0; if4.out_ready = 1'b0;
    step();
    step();

    // Reset values for all three widths
    check("rst_out_valid1", 128'(if1.out_valid), 128'(0));
    check("rst_out_state1", if1.out_state, '0);
    check("rst_busy1",      128'(if1.busy), 128'(0));
    check("rst_in_ready1",  128'(if1.in_ready), 128'(1));
    check("rst_in_ready2",  128'(if2.in_ready), 128'(1));
    check("rst_in_ready4",  128'(if4.in_ready), 128'(1));
    rst = 1'b0;

    // Test 1: vector 1, out_ready already high during RUN (no effect)
    if1.in_state = V1; if1.in_valid = 1'b1; if1.out_ready = 1'b1;
    step();
    check("t1_busy_after_accept", 128'(if1.busy), 128'(1));
    check("t1_in_ready_run",      128'(if1.in_ready), 128'(0));
    if1.in_valid = 1'b0; if1.in_state = JUNK;
    for (int k = 1; k <= 3; k++) begin
      step();
      check("t1_out_valid_early", 128'(if1.out_valid), 128'(0));
    end
    step();
    check("t1_out_valid_lat4", 128'(if1.out_valid), 128'(1));
    check("t1_out_state",      if1.out_state, R1);
    step();
    check("t1_out_valid_done", 128'(if1.out_valid), 128'(0));
    check("t1_in_ready_done",  128'(if1.in_ready), 128'(1));
    if1.out_ready = 1'b0;

    // Test 2: vector 2
    if1.in_state = V2; if1.in_valid = 1'b1;
    step();
    if1.in_valid = 1'b0;
    repeat (4) step();
    check("t2_out_valid", 128'(if1.out_valid), 128'(1));
    check("t2_out_state", if1.out_state, R2);

    // Test 3: back-pressure with a competing input offered
    if1.in_state = V3; if1.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("t3_hold_out_valid", 128'(if1.out_valid), 128'(1));
      check("t3_hold_out_state", if1.out_state, R2);
      check("t3_hold_in_ready",  128'(if1.in_ready), 128'(0));
    end
    if1.out_ready = 1'b1;
    step();
    check("t3_release_out_valid", 128'(if1.out_valid), 128'(0));
    check("t3_release_idle",      128'(if1.busy), 128'(0));
    check("t3_release_in_ready",  128'(if1.in_ready), 128'(1));
    if1.out_ready = 1'b0;
    step();
    check("t3_next_accepted", 128'(if1.busy), 128'(1));
    if1.in_valid = 1'b0;
    repeat (4) step();
    check("t3_v3_out_state", if1.out_state, R3);
    if1.out_ready = 1'b1;
    step();
    if1.out_ready = 1'b0;

    // Test 4: reset after two columns of RUN, with in_valid held during reset
    if1.in_state = V1; if1.in_valid = 1'b1;
    step();
    if1.in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    if1.in_state = V2; if1.in_valid = 1'b1;
    step();
    check("t4_rst_out_valid", 128'(if1.out_valid), 128'(0));
    check("t4_rst_out_state", if1.out_state, '0);
    check("t4_rst_in_ready",  128'(if1.in_ready), 128'(1));
    check("t4_rst_busy",      128'(if1.busy), 128'(0));
    rst = 1'b0;
    step();
    check("t4_accept_after_rst", 128'(if1.busy), 128'(1));
    if1.in_valid = 1'b0;
    repeat (3) step();
    check("t4_out_valid_early", 128'(if1.out_valid), 128'(0));
    step();
    check("t4_out_valid", 128'(if1.out_valid), 128'(1));
    check("t4_out_state", if1.out_state, R2);
    if1.out_ready = 1'b1;
    step();
    if1.out_ready = 1'b0;

    // Test 5: two and four columns per cycle
    if2.in_state = V1; if2.in_valid = 1'b1;
    if4.in_state = V1; if4.in_valid = 1'b1;
    step();
    if2.in_valid = 1'b0; if2.in_state = JUNK;
    if4.in_valid = 1'b0; if4.in_state = JUNK;
    step();
    check("t5_p4_out_valid",  128'(if4.out_valid), 128'(1));
    check("t5_p4_out_state",  if4.out_state, R1);
    check("t5_p2_out_valid0", 128'(if2.out_valid), 128'(0));
    step();
    check("t5_p2_out_valid",  128'(if2.out_valid), 128'(1));
    check("t5_p2_out_state",  if2.out_state, R1);
    if2.out_ready = 1'b1; if4.out_ready = 1'b1;
    step();
    check("t5_p2_done", 128'(if2.in_ready), 128'(1));
    check("t5_p4_done", 128'(if4.in_ready), 128'(1));
    if2.out_ready = 1'b0; if4.out_ready = 1'b0;

    // Second pass at wider widths with another vector
    if2.in_state = V3; if2.in_valid = 1'b1;
    if4.in_state = V3; if4.in_valid = 1'b1;
    step();
    if2.in_valid = 1'b0;
    if4.in_valid = 1'b0;
    step();
    check("t5b_p4_out_state", if4.out_state, R3);
    step();
    check("t5b_p2_out_state", if2.out_state, R3);
    check("t5b_p4_held",      if4.out_state, R3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
